// File: rtl/id_ex_hazard_ctrl_pkg.sv
// Shared types and constants for the ID/EX hazard controller.
// State encoding, register index width and the zero register.
package id_ex_hazard_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hz_state_e;

endpackage

// File: rtl/id_ex_hazard_ctrl_if.sv
// Hazard controller bus: ID/EX hazard inputs and pipeline write controls.
// StallCount/FlushCount exist only when HAZARD_STATS_EN is defined.
interface id_ex_hazard_ctrl_if;
  import id_ex_hazard_ctrl_pkg::*;

  logic [REG_W-1:0] ID_Rs;
  logic [REG_W-1:0] ID_Rt;
  logic             ID_UsesRt;
  logic             EX_MemRead;
  logic             EX_RegWrite;
  logic [REG_W-1:0] EX_WriteReg;
  logic             EX_jump;
  logic             EX_BranchTaken;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IFIDFlush;
  logic             IDEXBubble;
  logic             Stalled;
`ifdef HAZARD_STATS_EN
  logic [31:0]      StallCount;
  logic [31:0]      FlushCount;
`endif

  modport master (
`ifdef HAZARD_STATS_EN
    input  StallCount, FlushCount,
`endif
    output ID_Rs, ID_Rt, ID_UsesRt,
    output EX_MemRead, EX_RegWrite, EX_WriteReg,
    output EX_jump, EX_BranchTaken,
    input  PCWrite, IFIDWrite, IFIDFlush,
    input  IDEXBubble, Stalled
  );

  modport slave (
`ifdef HAZARD_STATS_EN
    output StallCount, FlushCount,
`endif
    input  ID_Rs, ID_Rt, ID_UsesRt,
    input  EX_MemRead, EX_RegWrite, EX_WriteReg,
    input  EX_jump, EX_BranchTaken,
    output PCWrite, IFIDWrite, IFIDFlush,
    output IDEXBubble, Stalled
  );

endinterface

// File: rtl/hazard_stat_ctr.sv
// 32-bit wrapping event counter with enable and sync active-low clear.
// Used for hazard statistics under HAZARD_STATS_EN.
module hazard_stat_ctr (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        en,
  output logic [31:0] count
);

  always_ff @(posedge Clk) begin
    if (!Reset)
      count <= '0;
    else if (en)
      count <= count + 32'd1;
  end

endmodule

// File: rtl/id_ex_hazard_ctrl.sv
// Load-use stall / redirect flush controller for the ID/EX register.
// Optional statistics counters enabled by HAZARD_STATS_EN.
module id_ex_hazard_ctrl
  import id_ex_hazard_ctrl_pkg::*;
#(
  parameter int STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic               Clk,
  input  logic               Reset,
  id_ex_hazard_ctrl_if.slave bus
);

  localparam logic [2:0] S_INIT = 3'(STALL_CYCLES - 2);
  localparam logic [2:0] F_INIT = 3'(FLUSH_CYCLES - 2);

  hz_state_e  state;
  logic [2:0] cnt;

  logic rs_hit;
  logic rt_hit;
  logic hazard;
  logic redirect;
  logic do_flush;
  logic do_stall;

  assign rs_hit = bus.EX_WriteReg == bus.ID_Rs;
  assign rt_hit = bus.ID_UsesRt
                & (bus.EX_WriteReg == bus.ID_Rt);

  assign hazard = bus.EX_MemRead
                & bus.EX_RegWrite
                & (bus.EX_WriteReg != ZERO_REG)
                & (rs_hit | rt_hit);

  assign redirect = bus.EX_jump | bus.EX_BranchTaken;

  // Redirect wins; a pending FLUSH masks any hazard.
  always_comb begin
    do_flush = redirect | (state == FLUSH);
    do_stall = !do_flush
             & ((state == STALL) | hazard);
  end

  always_comb begin
    bus.PCWrite    = !(Reset & do_stall);
    bus.IFIDWrite  = !(Reset & do_stall);
    bus.IFIDFlush  = Reset & do_flush;
    bus.IDEXBubble = Reset & (do_flush | do_stall);
    bus.Stalled    = Reset & do_stall;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= RUN;
      cnt   <= '0;
    end else if (state != FLUSH && redirect) begin
      if (FLUSH_CYCLES > 1) begin
        state <= FLUSH;
        cnt   <= F_INIT;
      end else begin
        state <= RUN;
      end
    end else begin
      case (state)
        STALL, FLUSH: begin
          if (cnt == 3'd0)
            state <= RUN;
          else
            cnt <= cnt - 3'd1;
        end
        default: begin
          if (hazard && STALL_CYCLES > 1) begin
            state <= STALL;
            cnt   <= S_INIT;
          end
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  hazard_stat_ctr u_stall_ctr (
    .Clk   (Clk),
    .Reset (Reset),
    .en    (bus.Stalled),
    .count (bus.StallCount)
  );

  hazard_stat_ctr u_flush_ctr (
    .Clk   (Clk),
    .Reset (Reset),
    .en    (bus.IFIDFlush),
    .count (bus.FlushCount)
  );
`endif

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Directed bench: instance A (stall 2, flush 1), instance B (stall 1, flush 3).
// Output vectors are {PCWrite,IFIDWrite,IFIDFlush,IDEXBubble,Stalled}.
module tb_id_ex_hazard_ctrl;

  localparam logic [4:0] IDLE = 5'b11000;
  localparam logic [4:0] STL  = 5'b00011;
  localparam logic [4:0] FLS  = 5'b11110;

  logic       clk;
  logic       rst;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       uses_rt;
  logic       mr;
  logic       rw;
  logic [4:0] wr;
  logic       jmp;
  logic       br;

  int tests = 0;
  int fails = 0;

  id_ex_hazard_ctrl_if ia ();
  id_ex_hazard_ctrl_if ib ();

  assign ia.ID_Rs          = rs;
  assign ia.ID_Rt          = rt;
  assign ia.ID_UsesRt      = uses_rt;
  assign ia.EX_MemRead     = mr;
  assign ia.EX_RegWrite    = rw;
  assign ia.EX_WriteReg    = wr;
  assign ia.EX_jump        = jmp;
  assign ia.EX_BranchTaken = br;

  assign ib.ID_Rs          = rs;
  assign ib.ID_Rt          = rt;
  assign ib.ID_UsesRt      = uses_rt;
  assign ib.EX_MemRead     = mr;
  assign ib.EX_RegWrite    = rw;
  assign ib.EX_WriteReg    = wr;
  assign ib.EX_jump        = jmp;
  assign ib.EX_BranchTaken = br;

  id_ex_hazard_ctrl #(
    .STALL_CYCLES (2),
    .FLUSH_CYCLES (1)
  ) dut_a (
    .Clk   (clk),
    .Reset (rst),
    .bus   (ia)
  );

  id_ex_hazard_ctrl #(
    .STALL_CYCLES (1),
    .FLUSH_CYCLES (3)
  ) dut_b (
    .Clk   (clk),
    .Reset (rst),
    .bus   (ib)
  );

  wire [4:0] oa = {ia.PCWrite, ia.IFIDWrite, ia.IFIDFlush,
                   ia.IDEXBubble, ia.Stalled};
  wire [4:0] ob = {ib.PCWrite, ib.IFIDWrite, ib.IFIDFlush,
                   ib.IDEXBubble, ib.Stalled};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk5(string tag, logic [4:0] obs, logic [4:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drv(logic [4:0] r_s, logic [4:0] r_t, logic u,
                     logic m, logic w, logic [4:0] d,
                     logic j, logic b);
    rs = r_s; rt = r_t; uses_rt = u;
    mr = m; rw = w; wr = d;
    jmp = j; br = b;
  endtask

  task automatic step(string tag, logic [4:0] ea, logic [4:0] eb);
    #3;
    chk5({tag, "_a"}, oa, ea);
    chk5({tag, "_b"}, ob, eb);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic haz();
    drv(5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    haz();
    #1;
    step("rst_force", IDLE, IDLE);
    step("rst_hold", IDLE, IDLE);
    rst = 1'b1;
    clr();
    step("run_idle", IDLE, IDLE);

    haz();
    step("lu_c1", STL, STL);
    drv(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0);
    step("lu_c2", STL, IDLE);
    step("lu_c3", IDLE, IDLE);

    drv(5'd1, 5'd9, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
    step("rt_nouse", IDLE, IDLE);
    drv(5'd1, 5'd9, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
    step("rt_use_c1", STL, STL);
    drv(5'd1, 5'd9, 1'b1, 1'b0, 1'b0, 5'd9, 1'b0, 1'b0);
    step("rt_use_c2", STL, IDLE);
    step("rt_use_c3", IDLE, IDLE);

    drv(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    step("zero_c1", IDLE, IDLE);
    step("zero_c2", IDLE, IDLE);
    drv(5'd8, 5'd0, 1'b0, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0);
    step("no_regwr", IDLE, IDLE);

    haz();
    step("rds_c1", STL, STL);
    drv(5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0);
    step("rds_c2", FLS, FLS);
    clr();
    step("rds_c3", IDLE, FLS);
    step("rds_c4", IDLE, FLS);
    step("rds_c5", IDLE, IDLE);

    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    step("fl_c1", FLS, FLS);
    haz();
    step("fl_c2", STL, FLS);
    clr();
    step("fl_c3", STL, FLS);
    step("fl_c4", IDLE, IDLE);

    haz();
    step("rst_stl_c1", STL, STL);
    rst = 1'b0;
    clr();
    step("rst_stl_c2", IDLE, IDLE);
    rst = 1'b1;
    step("rst_stl_c3", IDLE, IDLE);

    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    step("rst_fl_c1", FLS, FLS);
    rst = 1'b0;
    clr();
    step("rst_fl_c2", IDLE, IDLE);
    rst = 1'b1;
    step("rst_fl_c3", IDLE, IDLE);

    haz();
    step("st_c1", STL, STL);
    clr();
    step("st_c2", STL, IDLE);
    drv(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    step("st_c3", FLS, FLS);
    clr();
    step("st_c4", IDLE, FLS);
    step("st_c5", IDLE, FLS);
    #3;
`ifdef HAZARD_STATS_EN
    chk32("stall_cnt_a", ia.StallCount, 32'd2);
    chk32("flush_cnt_a", ia.FlushCount, 32'd1);
    chk32("stall_cnt_b", ib.StallCount, 32'd1);
    chk32("flush_cnt_b", ib.FlushCount, 32'd3);
`endif
    rst = 1'b0;
    @(posedge clk);
    #4;
    chk5("rst_end_a", oa, IDLE);
    chk5("rst_end_b", ob, IDLE);
`ifdef HAZARD_STATS_EN
    chk32("stall_clr_a", ia.StallCount, 32'd0);
    chk32("flush_clr_a", ia.FlushCount, 32'd0);
    chk32("stall_clr_b", ib.StallCount, 32'd0);
    chk32("flush_clr_b", ib.FlushCount, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_hazard_ctrl.md
# id_ex_hazard_ctrl

Pipeline hazard controller that drives the write side of the ID/EX pipeline register and the stages that feed it. It compares ID-stage source registers against the instruction held in EX to detect load-use hazards. It also reacts to EX-stage jumps and taken branches. It gates PC and IF/ID writes, flushes IF/ID, and injects bubbles (zeroed WB/MEM/EX control) into ID/EX.

## Interface
- STALL_CYCLES, 1: load-use stall length in cycles, 1..7 (2 when MEM→EX forwarding is absent)
- FLUSH_CYCLES, 1: redirect flush length in cycles, 1..7
- Clk  input  1  rising-edge clock
- Reset  input  1  synchronous, active-low reset; sampled only on the rising edge of Clk
- ID_Rs  input  5  rs field of the instruction in ID
- ID_Rt  input  5  rt field of the instruction in ID
- ID_UsesRt  input  1  ID instruction reads rt
- EX_MemRead  input  1  EX instruction is a load
- EX_RegWrite  input  1  EX instruction writes the register file
- EX_WriteReg  input  5  EX destination register, after the RegDst mux
- EX_jump  input  1  jump in EX
- EX_BranchTaken  input  1  taken branch resolved in EX
- PCWrite  output  1  PC update enable
- IFIDWrite  output  1  IF/ID update enable
- IFIDFlush  output  1  zero IF/ID on the next edge
- IDEXBubble  output  1  force ID/EX WB/MEM/EX control to 0 on the next edge
- Stalled  output  1  status: stall in progress

## Operation
- Hazard: EX_MemRead & EX_RegWrite & (EX_WriteReg != 0) & ((EX_WriteReg == ID_Rs) | (ID_UsesRt & (EX_WriteReg == ID_Rt)))
- Redirect: EX_jump | EX_BranchTaken
- FSM states RUN, STALL, FLUSH, plus a 3-bit down-counter cnt.
- RUN, with redirect:
  - Outputs: PCWrite=1, IFIDWrite=1, IFIDFlush=1, IDEXBubble=1.
  - If FLUSH_CYCLES>1: go to FLUSH with cnt=FLUSH_CYCLES-2.
- RUN, with hazard and no redirect:
  - Outputs: PCWrite=0, IFIDWrite=0, IDEXBubble=1, Stalled=1.
  - If STALL_CYCLES>1: go to STALL with cnt=STALL_CYCLES-2.
- RUN, otherwise: PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXBubble=0.
- STALL:
  - Outputs: same as RUN hazard outputs, regardless of the hazard input.
  - When cnt=0, return to RUN; otherwise decrement cnt.
  - A redirect in STALL aborts the stall: RUN redirect outputs this cycle, and the next state follows the RUN redirect rule.
- FLUSH:
  - Outputs: same as RUN redirect outputs.
  - When cnt=0, return to RUN; otherwise decrement cnt.
  - Hazards are ignored in FLUSH.
- Priority: redirect > stall > run.

## Timing
- All outputs are Mealy, decoded combinationally from state and inputs in the same cycle. Zero-cycle detection latency.
- A single-cycle stall or flush uses no extra state; the FSM stays in RUN.
- Total stall length is exactly STALL_CYCLES cycles of PCWrite=0. Total flush length is exactly FLUSH_CYCLES cycles of IFIDFlush=1.
- Reset low at a rising edge:
  - state=RUN, cnt=0, statistics counters=0.
  - While Reset is low, outputs are forced to PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXBubble=0, Stalled=0.
- Reset mid-stall or mid-flush abandons the sequence with no residual cycles.
- EX_WriteReg=0 never causes a stall.

## Configuration
- HAZARD_STATS_EN defined:
  - Adds outputs StallCount[31:0] and FlushCount[31:0].
  - StallCount increments on every cycle Stalled=1; FlushCount increments on every cycle IFIDFlush=1.
  - Both wrap modulo 2^32 and clear on reset.
- HAZARD_STATS_EN undefined: neither port nor the counters exist. Hazard behaviour is otherwise identical.

## Structure
- A shared package holds:
  - the state encoding (RUN=2'd0, STALL=2'd1, FLUSH=2'd2);
  - the register-index width constant (5);
  - the zero-register constant.
- The statistics counters form one natural sub-module, hazard_stat_ctr (one 32-bit wrapping counter with enable and synchronous active-low clear), instantiated twice under HAZARD_STATS_EN.

## Test plan
- Load-use stall: EX_MemRead=1, EX_RegWrite=1, EX_WriteReg=8, ID_Rs=8, STALL_CYCLES=2 -> PCWrite=0, IFIDWrite=0, IDEXBubble=1 for exactly 2 cycles, then 1/1/0.
- rt-only case: EX_WriteReg=9, ID_Rt=9, ID_UsesRt=0 -> no stall; with ID_UsesRt=1 -> stall.
- Zero register: EX_WriteReg=0, ID_Rs=0, load in EX -> no stall, PCWrite=1 throughout.
- Redirect during STALL: EX_jump=1 in the second stall cycle -> that cycle PCWrite=1, IFIDFlush=1, IDEXBubble=1; RUN on the next cycle with FLUSH_CYCLES=1.
- Flush length: FLUSH_CYCLES=3 with EX_BranchTaken pulsed for 1 cycle -> IFIDFlush=1 for 3 consecutive cycles; a hazard presented during FLUSH is ignored.
- Reset and statistics: Reset=0 mid-STALL -> next cycle idle outputs. With HAZARD_STATS_EN, after 2 stall cycles and 3 flush cycles: StallCount=2, FlushCount=3; reset clears both to 0.
